// File: rtl/activation_backprop_if.sv
// Handshake bundle for activation_backprop: forward-sum push, error pop,
// delta output and status.
interface activation_backprop_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic [1:0]        act_sel;
    logic              fwd_valid;
    logic              fwd_ready;
    logic [DATA_W-1:0] fwd_sum;
    logic              err_valid;
    logic              err_ready;
    logic [DATA_W-1:0] err_in;
    logic              delta_valid;
    logic              delta_ready;
    logic [DATA_W-1:0] delta_out;
    logic [CNT_W-1:0]  count;
    logic              cfg_err;

    modport master (
        output flush, act_sel, fwd_valid, fwd_sum, err_valid, err_in, delta_ready,
        input  fwd_ready, err_ready, delta_valid, delta_out, count, cfg_err
    );

    modport slave (
        input  flush, act_sel, fwd_valid, fwd_sum, err_valid, err_in, delta_ready,
        output fwd_ready, err_ready, delta_valid, delta_out, count, cfg_err
    );
endinterface

// File: rtl/activation_backprop.sv
// Backward-pass local-gradient stage: buffers forward sums, pairs each error with
// its sum in order. Optional macro LEAKY_RELU_EN enables Leaky ReLU on act_sel = 3.
module activation_backprop #(
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 8,
    parameter int DEPTH      = 8,
    parameter int LEAK_SHIFT = 3
) (
    input logic                  clk,
    input logic                  rst_n,
    activation_backprop_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]         FULL_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]         CNT_ONE_C = CNT_W'(1);
    localparam logic [PTR_W-1:0]         PTR_ONE_C = PTR_W'(1);
    localparam logic signed [DATA_W-1:0] ZERO_C    = DATA_W'(32'sd0);
    localparam logic signed [DATA_W-1:0] ONE_C     = DATA_W'(32'sd1 <<< FRAC_W);
    localparam logic signed [DATA_W-1:0] NEG_ONE_C = -ONE_C;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              delta_valid_r;
    logic [DATA_W-1:0] delta_out_r;
    logic              cfg_err_r;

    logic              fwd_ready_s;
    logic              err_ready_s;
    logic              push_s;
    logic              pop_s;
    logic [DATA_W-1:0] rd_sum_s;
    logic [DATA_W-1:0] grad_s;

    // Local gradient err * f'(sum); every derivative is 0, 1 or a power-of-two slope.
    function automatic logic [DATA_W-1:0] grad_f(
        input logic [1:0]               sel,
        input logic signed [DATA_W-1:0] s,
        input logic signed [DATA_W-1:0] e
    );
        logic [DATA_W-1:0] d;
        case (sel)
            2'd0:    d = e;
            2'd1:    d = ((s >= NEG_ONE_C) && (s <= ONE_C)) ? e : '0;
            2'd2:    d = (s > ZERO_C) ? e : '0;
`ifdef LEAKY_RELU_EN
            2'd3:    d = (s > ZERO_C) ? e : (e >>> LEAK_SHIFT);
`else
            2'd3:    d = '0;
`endif
            default: d = '0;
        endcase
        return d;
    endfunction

`ifndef LEAKY_RELU_EN
    logic unused_leak_s;
    assign unused_leak_s = (LEAK_SHIFT > 0);
`endif

    // Handshake qualification from registered count and the output-stage state
    always_comb begin
        fwd_ready_s = (count_r != FULL_C);
        err_ready_s = (count_r != '0) && (!delta_valid_r || bus.delta_ready);
        push_s      = bus.fwd_valid && fwd_ready_s;
        pop_s       = bus.err_valid && err_ready_s;
        rd_sum_s    = mem_r[rd_ptr_r];
        grad_s      = grad_f(bus.act_sel, rd_sum_s, bus.err_in);
    end

    // Sum storage; stale entries after a flush are never read because count gates pops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s && !bus.flush) begin
            mem_r[wr_ptr_r] <= bus.fwd_sum;
        end
    end

    // Pointers, occupancy and the registered delta output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            delta_valid_r <= 1'b0;
            delta_out_r   <= '0;
        end else if (bus.flush) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            delta_valid_r <= 1'b0;
            delta_out_r   <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE_C;
                2'b01:   count_r <= count_r - CNT_ONE_C;
                default: count_r <= count_r;
            endcase
            // A pop with delta_ready high overwrites the consumed result without a bubble
            if (pop_s) begin
                delta_out_r   <= grad_s;
                delta_valid_r <= 1'b1;
            end else if (bus.delta_ready) begin
                delta_valid_r <= 1'b0;
            end
        end
    end

    // Sticky configuration error, cleared only by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_r <= 1'b0;
        end else begin
`ifdef LEAKY_RELU_EN
            cfg_err_r <= cfg_err_r;
`else
            if (pop_s && !bus.flush && (bus.act_sel == 2'd3)) begin
                cfg_err_r <= 1'b1;
            end
`endif
        end
    end

    assign bus.fwd_ready   = fwd_ready_s;
    assign bus.err_ready   = err_ready_s;
    assign bus.delta_valid = delta_valid_r;
    assign bus.delta_out   = delta_out_r;
    assign bus.count       = count_r;
    assign bus.cfg_err     = cfg_err_r;
endmodule

// File: tb/tb_activation_backprop.sv
// Scoreboard bench for activation_backprop: directed vectors queue expected
// deltas; a negedge monitor checks value, latency and stall stability.
module tb_activation_backprop;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } sb_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    logic mon_hold;
    sb_t  sb_q[$];

    activation_backprop_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    activation_backprop #(.DATA_W(DATA_W), .FRAC_W(8), .DEPTH(DEPTH), .LEAK_SHIFT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented delta against the scoreboard head
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.delta_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_delta", {16'h0, bus.delta_out}, 32'hDEAD_BEEF);
                end else begin
                    check("delta_data", {16'h0, bus.delta_out}, {16'h0, sb_q[0].data});
                    if (!mon_hold) check("delta_latency", cyc, sb_q[0].cyc);
                    if (bus.delta_ready) void'(sb_q.pop_front());
                end
            end
            mon_hold <= bus.delta_valid && !bus.delta_ready;
        end else begin
            mon_hold <= 1'b0;
        end
    end

    task automatic push_sum(input logic [15:0] s);
        int n = 0;
        bus.fwd_valid = 1'b1;
        bus.fwd_sum   = s;
        @(negedge clk);
        while (!bus.fwd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.fwd_ready) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.fwd_valid = 1'b0;
    endtask

    task automatic send_err(input logic [15:0] e, input logic [1:0] sel, input logic [15:0] exp_d);
        int n = 0;
        bus.err_valid = 1'b1;
        bus.err_in    = e;
        bus.act_sel   = sel;
        @(negedge clk);
        while (!bus.err_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.err_ready) check("err_timeout", 32'd0, 32'd1);
        else sb_q.push_back('{exp_d, cyc + 1});
        @(posedge clk);
        #1;
        bus.err_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fwd_ready"},   {31'h0, bus.fwd_ready},   32'd1);
        check({tag, "_err_ready"},   {31'h0, bus.err_ready},   32'd0);
        check({tag, "_delta_valid"}, {31'h0, bus.delta_valid}, 32'd0);
        check({tag, "_delta_out"},   {16'h0, bus.delta_out},   32'd0);
        check({tag, "_count"},       {28'h0, bus.count},       32'd0);
        check({tag, "_cfg_err"},     {31'h0, bus.cfg_err},     32'd0);
    endtask

    initial begin
        logic [15:0] bs_sum [4];
        logic [15:0] bs_exp [4];
        checks = 0;
        errors = 0;
        cyc = 0;
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.act_sel = 2'd0;
        bus.fwd_valid = 1'b0;
        bus.fwd_sum = 16'h0;
        bus.err_valid = 1'b0;
        bus.err_in = 16'h0;
        bus.delta_ready = 1'b1;
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ReLU ordering
        push_sum(16'h0200);
        push_sum(16'hFF00);
        push_sum(16'h0000);
        check("relu_count", {28'h0, bus.count}, 32'd3);
        send_err(16'h0040, 2'd2, 16'h0040);
        send_err(16'h0040, 2'd2, 16'h0000);
        send_err(16'h0040, 2'd2, 16'h0000);
        drain();
        check("relu_empty", {28'h0, bus.count}, 32'd0);

        // Binary-step straight-through window at exactly +/-1.0
        bs_sum = '{16'h0100, 16'h0101, 16'hFF00, 16'hFEFF};
        bs_exp = '{16'hFF80, 16'h0000, 16'hFF80, 16'h0000};
        for (int i = 0; i < 4; i++) push_sum(bs_sum[i]);
        for (int i = 0; i < 4; i++) send_err(16'hFF80, 2'd1, bs_exp[i]);
        drain();

        // Identity passes the error regardless of sum
        push_sum(16'h8000);
        send_err(16'hABCD, 2'd0, 16'hABCD);
        drain();

        // Full boundary
        for (int i = 0; i < DEPTH; i++) push_sum(16'(i + 1));
        check("full_count", {28'h0, bus.count}, 32'd8);
        check("full_fwd_ready", {31'h0, bus.fwd_ready}, 32'd0);
        bus.fwd_valid = 1'b1;
        bus.fwd_sum = 16'h7777;
        bus.err_valid = 1'b1;
        bus.err_in = 16'h0011;
        bus.act_sel = 2'd0;
        @(negedge clk);
        check("full_pp_fwd_ready", {31'h0, bus.fwd_ready}, 32'd0);
        check("full_pp_err_ready", {31'h0, bus.err_ready}, 32'd1);
        sb_q.push_back('{16'h0011, cyc + 1});
        @(posedge clk);
        #1;
        bus.fwd_valid = 1'b0;
        bus.err_valid = 1'b0;
        check("full_pp_count", {28'h0, bus.count}, 32'd7);
        bus.fwd_valid = 1'b1;
        bus.fwd_sum = 16'h0009;
        bus.err_valid = 1'b1;
        bus.err_in = 16'h0022;
        @(negedge clk);
        check("seven_pp_fwd_ready", {31'h0, bus.fwd_ready}, 32'd1);
        check("seven_pp_err_ready", {31'h0, bus.err_ready}, 32'd1);
        sb_q.push_back('{16'h0022, cyc + 1});
        @(posedge clk);
        #1;
        bus.fwd_valid = 1'b0;
        bus.err_valid = 1'b0;
        check("seven_pp_count", {28'h0, bus.count}, 32'd7);
        for (int i = 0; i < 7; i++) send_err(16'(16'h0100 + i), 2'd0, 16'(16'h0100 + i));
        drain();
        check("drained_count", {28'h0, bus.count}, 32'd0);

        // Empty boundary: error must not be accepted
        bus.err_valid = 1'b1;
        bus.err_in = 16'h1111;
        repeat (3) begin
            @(negedge clk);
            check("empty_err_ready", {31'h0, bus.err_ready}, 32'd0);
            check("empty_delta_valid", {31'h0, bus.delta_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.err_valid = 1'b0;

        // Backpressure with a second error pending
        push_sum(16'h0100);
        push_sum(16'h0200);
        bus.delta_ready = 1'b0;
        send_err(16'h0A0A, 2'd0, 16'h0A0A);
        bus.err_valid = 1'b1;
        bus.err_in = 16'h0B0B;
        repeat (3) begin
            @(negedge clk);
            check("stall_err_ready", {31'h0, bus.err_ready}, 32'd0);
            check("stall_delta_valid", {31'h0, bus.delta_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        bus.delta_ready = 1'b1;
        @(negedge clk);
        check("release_err_ready", {31'h0, bus.err_ready}, 32'd1);
        sb_q.push_back('{16'h0B0B, cyc + 1});
        @(posedge clk);
        #1;
        bus.err_valid = 1'b0;
        drain();

        // act_sel = 3
        push_sum(16'hFF00);
`ifdef LEAKY_RELU_EN
        send_err(16'h0080, 2'd3, 16'h0010);
        drain();
        check("act3_cfg_err", {31'h0, bus.cfg_err}, 32'd0);
`else
        send_err(16'h0080, 2'd3, 16'h0000);
        drain();
        check("act3_cfg_err", {31'h0, bus.cfg_err}, 32'd1);
`endif
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
`ifdef LEAKY_RELU_EN
        check("act3_cfg_err_after_flush", {31'h0, bus.cfg_err}, 32'd0);
`else
        check("act3_cfg_err_after_flush", {31'h0, bus.cfg_err}, 32'd1);
`endif

        // Flush mid-stream
        for (int i = 0; i < 5; i++) push_sum(16'(16'h0300 + i));
        bus.delta_ready = 1'b0;
        send_err(16'h0033, 2'd0, 16'h0033);
        check("preflush_count", {28'h0, bus.count}, 32'd4);
        check("preflush_delta_valid", {31'h0, bus.delta_valid}, 32'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        sb_q.delete();
        check("flush_count", {28'h0, bus.count}, 32'd0);
        check("flush_delta_valid", {31'h0, bus.delta_valid}, 32'd0);
        check("flush_err_ready", {31'h0, bus.err_ready}, 32'd0);
        bus.delta_ready = 1'b1;

        // Asynchronous reset mid-stream, checked before any clock edge
        for (int i = 0; i < 3; i++) push_sum(16'(16'h0400 + i));
        bus.delta_ready = 1'b0;
        send_err(16'h0044, 2'd0, 16'h0044);
        check("prerst_delta_valid", {31'h0, bus.delta_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.delta_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
